// File: rtl/io_port_pkg.sv
// rtl/io_port_pkg.sv - register offsets, channel stride and register select type for the MMIO port bank
package io_port_pkg;

   localparam int CH_STRIDE = 16;

   localparam logic [3:0] OFF_DIN  = 4'h0;
   localparam logic [3:0] OFF_DOUT = 4'h4;
   localparam logic [3:0] OFF_EDGE = 4'h8;
   localparam logic [3:0] OFF_MASK = 4'hC;

   typedef enum logic [1:0] {
      SEL_DIN  = 2'd0,
      SEL_DOUT = 2'd1,
      SEL_EDGE = 2'd2,
      SEL_MASK = 2'd3
   } reg_sel_t;

   // Byte offset within a channel to register select; Addr[1:0] is don't-care.
   function automatic reg_sel_t off_to_sel(input logic [3:0] off);
      reg_sel_t sel;
      case ({off[3:2], 2'b00})
         OFF_DIN:  sel = SEL_DIN;
         OFF_DOUT: sel = SEL_DOUT;
         OFF_EDGE: sel = SEL_EDGE;
         default:  sel = SEL_MASK;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/io_port_channel.sv
// rtl/io_port_channel.sv - one port channel: input synchroniser, DOUT, sticky EDGE with W1C, MASK and read mux
module io_port_channel
   import io_port_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             warm_i,
   input  logic             wr_en_i,
   input  reg_sel_t         sel_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [WIDTH-1:0] in_i,
   output logic [WIDTH-1:0] out_o,
   output logic [WIDTH-1:0] rdata_o,
   output logic             irq_o
);

   logic [WIDTH-1:0] sync1_q, sync2_q, prev_q, prev_d;
   logic [WIDTH-1:0] dout_q, dout_d, edge_q, edge_d, mask_q, mask_d;
   logic [WIDTH-1:0] rise, clr;

   always_comb begin
      rise   = warm_i ? '0 : (sync2_q & ~prev_q);
      clr    = (wr_en_i && sel_i == SEL_EDGE) ? wdata_i : '0;
      edge_d = (edge_q & ~clr) | rise;
      dout_d = (wr_en_i && sel_i == SEL_DOUT) ? wdata_i : dout_q;
      mask_d = (wr_en_i && sel_i == SEL_MASK) ? wdata_i : mask_q;
      // While warming up, prev follows the value sync2 is about to take, so
      // both agree by the time edge detection is enabled.
      prev_d = warm_i ? sync1_q : sync2_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         dout_q  <= '0;
         edge_q  <= '0;
         mask_q  <= '0;
      end else begin
         sync1_q <= in_i;
         sync2_q <= sync1_q;
         prev_q  <= prev_d;
         dout_q  <= dout_d;
         edge_q  <= edge_d;
         mask_q  <= mask_d;
      end
   end

   always_comb begin
      case (sel_i)
         SEL_DIN:  rdata_o = sync2_q;
         SEL_DOUT: rdata_o = dout_q;
         SEL_EDGE: rdata_o = edge_q;
         default:  rdata_o = mask_q;
      endcase
   end

   assign out_o = dout_q;
   assign irq_o = |(edge_q & mask_q);

endmodule

// File: rtl/mmio_port_bank.sv
// rtl/mmio_port_bank.sv - NCH-channel memory-mapped I/O port bank on the single-cycle data bus
module mmio_port_bank
   import io_port_pkg::*;
#(
   parameter int          NCH   = 2,
   parameter int          WIDTH = 8,
   parameter logic [31:0] BASE  = 32'h800
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [31:0]          Addr,
   input  logic [31:0]          WriteData,
   input  logic                 MemWrite,
   input  logic                 MemRead,
   output logic                 PortSel,
   output logic [31:0]          ReadData,
   input  logic [NCH*WIDTH-1:0] INport,
   output logic [NCH*WIDTH-1:0] OUTport,
   output logic                 irq
);

   localparam int          IW    = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [31:0] LIMIT = BASE + 32'(CH_STRIDE * NCH);

   logic [IW-1:0]        ch_idx;
   reg_sel_t             sel;
   logic [NCH-1:0]       ch_hit, ch_irq;
   logic [NCH*WIDTH-1:0] rdata_flat;
   logic [1:0]           warm_cnt_q, warm_cnt_d;
   logic                 warm, irq_d;
   logic                 unused_ok;

   // Loads carry no side effects, so the read strobe is not needed internally.
   assign unused_ok = &{1'b0, MemRead, WriteData};

   assign PortSel = (Addr >= BASE) && (Addr < LIMIT);
   assign ch_idx  = Addr[4 +: IW];
   assign sel     = off_to_sel(Addr[3:0]);
   assign warm    = (warm_cnt_q < 2'd2);

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign ch_hit[c] = PortSel && (ch_idx == IW'(c));

      io_port_channel #(.WIDTH(WIDTH)) u_ch (
         .clk     (clk),
         .reset   (reset),
         .warm_i  (warm),
         .wr_en_i (MemWrite && ch_hit[c]),
         .sel_i   (sel),
         .wdata_i (WriteData[WIDTH-1:0]),
         .in_i    (INport[c*WIDTH +: WIDTH]),
         .out_o   (OUTport[c*WIDTH +: WIDTH]),
         .rdata_o (rdata_flat[c*WIDTH +: WIDTH]),
         .irq_o   (ch_irq[c])
      );
   end

   always_comb begin
      ReadData = '0;
      for (int c = 0; c < NCH; c++) begin
         if (ch_hit[c]) ReadData = ReadData | 32'(rdata_flat[c*WIDTH +: WIDTH]);
      end
   end

   always_comb begin
      warm_cnt_d = warm ? (warm_cnt_q + 2'd1) : warm_cnt_q;
      irq_d      = |ch_irq;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         warm_cnt_q <= '0;
         irq        <= 1'b0;
      end else begin
         warm_cnt_q <= warm_cnt_d;
         irq        <= irq_d;
      end
   end

endmodule

// File: tb/tb_mmio_port_bank.sv
// tb/tb_mmio_port_bank.sv - directed self-checking bench for mmio_port_bank (NCH=2, WIDTH=8, BASE=0x800)
module tb_mmio_port_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Addr, WriteData;
   logic        MemWrite, MemRead;
   logic        PortSel;
   logic [31:0] ReadData;
   logic [15:0] INport, OUTport;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   mmio_port_bank #(.NCH(2), .WIDTH(8), .BASE(32'h800)) dut (
      .clk       (clk),
      .reset     (reset),
      .Addr      (Addr),
      .WriteData (WriteData),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .PortSel   (PortSel),
      .ReadData  (ReadData),
      .INport    (INport),
      .OUTport   (OUTport),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      Addr      = a;
      WriteData = d;
      MemWrite  = 1'b1;
      tick();
      MemWrite  = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
      Addr    = a;
      MemRead = 1'b1;
      #1;
      check(tag, ReadData, exp);
      MemRead = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0; Addr = '0; WriteData = '0; MemWrite = 1'b0; MemRead = 1'b0;
      INport = 16'hFFFF;

      // 1: reset with inputs high, no false edge after release
      #12;
      check("rst_outport", OUTport, 0);
      check("rst_irq", irq, 0);
      #10 reset = 1'b1;
      check("rel_outport", OUTport, 0);
      tick(); tick(); tick();
      rd("din0_after_rst", 32'h800, 32'hFF);
      rd("din1_after_rst", 32'h810, 32'hFF);
      rd("edge0_no_false", 32'h808, 32'h0);
      rd("edge1_no_false", 32'h818, 32'h0);
      check("irq_after_rst", irq, 0);
      INport = 16'h0000;
      tick(); tick(); tick();
      rd("edge0_fall_ignored", 32'h808, 32'h0);

      // 2: DOUT stores and readback
      wr(32'h804, 32'hA5);
      check("outport_ch0", OUTport, 16'h00A5);
      wr(32'h814, 32'h3C);
      check("outport_both", OUTport, 16'h3CA5);
      rd("dout0_rd", 32'h804, 32'h0000_00A5);
      rd("dout1_rd", 32'h814, 32'h0000_003C);
      Addr = 32'h800; #1;
      check("portsel_800", PortSel, 1);
      wr(32'h804, 32'hFFFF_FF5A);
      rd("dout0_upper_dropped", 32'h804, 32'h5A);
      wr(32'h804, 32'hA5);
      wr(32'h800, 32'h55);
      rd("din_write_ignored", 32'h800, 32'h0);

      // 3: masked edge raises irq, W1C drops it
      wr(32'h80C, 32'h01);
      rd("mask0_rd", 32'h80C, 32'h01);
      INport = 16'h0001;
      tick(); tick();
      rd("edge0_before_3", 32'h808, 32'h0);
      tick();
      rd("edge0_set", 32'h808, 32'h01);
      check("irq_not_yet", irq, 0);
      tick();
      check("irq_set", irq, 1);
      wr(32'h808, 32'h01);
      rd("edge0_cleared", 32'h808, 32'h0);
      check("irq_lags_clear", irq, 1);
      tick();
      check("irq_dropped", irq, 0);
      INport = 16'h0003;
      tick(); tick(); tick();
      rd("edge0_bit1", 32'h808, 32'h02);
      tick();
      check("irq_unmasked_bit", irq, 0);

      // 4: edge and W1C on the same bit in the same cycle: set wins
      INport = 16'h0103;
      tick(); tick(); tick();
      rd("edge1_first", 32'h818, 32'h01);
      INport = 16'h0003;
      tick(); tick(); tick();
      INport = 16'h0103;
      tick(); tick();
      wr(32'h818, 32'h01);
      rd("edge1_set_wins", 32'h818, 32'h01);
      wr(32'h818, 32'h01);
      rd("edge1_plain_clear", 32'h818, 32'h0);

      // 5: out-of-window addresses
      wr(32'h81C, 32'h80);
      Addr = 32'h820; #1;
      check("ps_820", PortSel, 0);
      check("rd_820", ReadData, 0);
      Addr = 32'h7FC; #1;
      check("ps_7fc", PortSel, 0);
      check("rd_7fc", ReadData, 0);
      Addr = 32'h1800; #1;
      check("ps_1800", PortSel, 0);
      check("rd_1800", ReadData, 0);
      wr(32'h824, 32'hFF);
      wr(32'h1804, 32'h11);
      wr(32'h7FC, 32'h7F);
      check("oow_outport", OUTport, 16'h3CA5);
      rd("oow_mask1", 32'h81C, 32'h80);
      rd("oow_mask0", 32'h80C, 32'h01);

      // 6: asynchronous reset during a store, with irq high
      wr(32'h80C, 32'h03);
      check("irq_pre", irq, 0);
      tick();
      check("irq_before_rst", irq, 1);
      Addr = 32'h804; WriteData = 32'h77; MemWrite = 1'b1;
      #2 reset = 1'b0;
      #1;
      check("async_outport", OUTport, 0);
      check("async_irq", irq, 0);
      rd("async_edge0", 32'h808, 32'h0);
      rd("async_mask0", 32'h80C, 32'h0);
      Addr = 32'h804;
      tick();
      MemWrite = 1'b0;
      reset = 1'b1;
      tick(); tick(); tick();
      rd("store_lost", 32'h804, 32'h0);
      check("outport_after_rst", OUTport, 0);
      rd("edge0_no_false_2", 32'h808, 32'h0);
      rd("din0_after_rst2", 32'h800, 32'h03);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
